instr_mem_loader: RTL and testbench

- Streaming MIPS instruction encoder and loader; the writer side of the opcode/control decode path.
- Accepts instruction fields (opcode, rs, rt, rd, shamt, funct, imm, target) over a valid/ready handshake.
- Packs each field set into a 32-bit MIPS word (R, I or J format) and writes it into instruction memory at auto-incrementing word addresses.
- Sits between the bench/boot host and instruction memory; the processor later fetches these words and decodes Instruction[31:26].

---
 rtl/mips_isa_pkg.sv | 60 ++++++
 rtl/instr_mem_loader_if.sv | 34 +++
 rtl/instr_field_pack.sv | 50 +++++
 rtl/instr_mem_loader.sv | 130 +++++++++++++
 tb/tb_instr_mem_loader.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_isa_pkg.sv
// MIPS ISA constants shared by the instruction loader and the control decoder.
// Holds opcode values, the instruction-format classification and field positions.
// op_format() maps a 6-bit opcode to the word layout it uses.
package mips_isa_pkg;

  // Opcodes (Instruction[31:26])
  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] J     = 6'b000010;
  localparam logic [5:0] JAL   = 6'b000011;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] BNE   = 6'b000101;
  localparam logic [5:0] ADDI  = 6'b001000;
  localparam logic [5:0] ADDIU = 6'b001001;
  localparam logic [5:0] SLTI  = 6'b001010;
  localparam logic [5:0] SLTIU = 6'b001011;
  localparam logic [5:0] ANDI  = 6'b001100;
  localparam logic [5:0] ORI   = 6'b001101;
  localparam logic [5:0] XORI  = 6'b001110;
  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] NOP   = 6'b110110;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_J,
    FMT_NOP,
    FMT_BAD
  } fmt_e;

  // Field bit positions within the 32-bit word
  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SH_MSB    = 10;
  localparam int SH_LSB    = 6;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;
  localparam int TGT_MSB   = 25;
  localparam int TGT_LSB   = 0;

  function automatic fmt_e op_format(input logic [5:0] op);
    case (op)
      RTYPE:                     return FMT_R;
      J, JAL:                    return FMT_J;
      LW, SW, BEQ, BNE, ADDI, ADDIU,
      ANDI, ORI, XORI, SLTI, SLTIU: return FMT_I;
      NOP:                       return FMT_NOP;
      default:                   return FMT_BAD;
    endcase
  endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Field-set input handshake plus instruction-memory write bus of the loader.
// master: host side (drives fields, in_valid, mem_ready); slave: loader side.
// Field set moves on in_valid&in_ready; a word is written on mem_we&mem_ready.
interface instr_mem_loader_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        in_op;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [5:0]        in_funct;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_funct,
           in_imm, in_target, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_funct,
           in_imm, in_target, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/instr_field_pack.sv
// Classifies an opcode and packs the instruction fields into a 32-bit MIPS word.
// Purely combinational (0 cycles); no handshake.
// Ports: op_i..target_i fields in; word_o packed word, bad_o unsupported opcode.
module instr_field_pack
  import mips_isa_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [5:0]  funct_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        bad_o
);

  fmt_e fmt;

  always_comb begin
    fmt    = op_format(op_i);
    word_o = '0;
    bad_o  = 1'b0;
    case (fmt)
      FMT_R: begin
        word_o[OP_MSB:OP_LSB]       = op_i;
        word_o[RS_MSB:RS_LSB]       = rs_i;
        word_o[RT_MSB:RT_LSB]       = rt_i;
        word_o[RD_MSB:RD_LSB]       = rd_i;
        word_o[SH_MSB:SH_LSB]       = shamt_i;
        word_o[FUNCT_MSB:FUNCT_LSB] = funct_i;
      end
      FMT_I: begin
        word_o[OP_MSB:OP_LSB]   = op_i;
        word_o[RS_MSB:RS_LSB]   = rs_i;
        word_o[RT_MSB:RT_LSB]   = rt_i;
        word_o[IMM_MSB:IMM_LSB] = imm_i;
      end
      FMT_J: begin
        word_o[OP_MSB:OP_LSB]   = op_i;
        word_o[TGT_MSB:TGT_LSB] = target_i;
      end
      // NOP carries no operands: low 26 bits stay zero whatever the inputs say
      FMT_NOP: word_o[OP_MSB:OP_LSB] = NOP;
      default: bad_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Streams field sets in, packs them to MIPS words, writes them to consecutive addresses.
// Latency: handshake to mem_we is 1 cycle; at most one word every 2 cycles.
// Backpressure: in_ready low while a write waits; mem_we/addr/wdata held until mem_ready.
// Ports: clk/rst_n; start+base_addr+length begin a load; bus carries the field
// handshake and memory write; busy/done status, err/wrapped sticky until next start.
module instr_mem_loader
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  instr_mem_loader_if.slave bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              wrapped
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCEPT = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  written_q, written_d;
  logic [31:0]       word_q, word_d;
  logic              err_q, err_d;
  logic              wrapped_q, wrapped_d;

  logic [31:0] pack_word;
  logic        pack_bad;

  instr_field_pack u_pack (
    .op_i     (bus.in_op),
    .rs_i     (bus.in_rs),
    .rt_i     (bus.in_rt),
    .rd_i     (bus.in_rd),
    .shamt_i  (bus.in_shamt),
    .funct_i  (bus.in_funct),
    .imm_i    (bus.in_imm),
    .target_i (bus.in_target),
    .word_o   (pack_word),
    .bad_o    (pack_bad)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    written_d = written_q;
    word_d    = word_q;
    err_d     = err_q;
    wrapped_d = wrapped_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length != '0) begin
            addr_d    = base_addr;
            len_d     = length;
            written_d = '0;
            err_d     = 1'b0;
            wrapped_d = 1'b0;
            state_d   = S_ACCEPT;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ACCEPT: begin
        if (bus.in_valid) begin
          // Unsupported opcodes still complete the handshake so the host never stalls
          if (pack_bad) begin
            err_d = 1'b1;
          end else begin
            word_d  = pack_word;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (bus.mem_ready) begin
          addr_d    = addr_q + ADDR_W'(1);
          written_d = written_q + LEN_W'(1);
          if (&addr_q) wrapped_d = 1'b1;
          state_d = (written_d == len_q) ? S_DONE : S_ACCEPT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      written_q <= '0;
      word_q    <= '0;
      err_q     <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      written_q <= written_d;
      word_q    <= word_d;
      err_q     <= err_d;
      wrapped_q <= wrapped_d;
    end
  end

  // Outputs decode straight from the state register so reset clears them at once
  assign bus.in_ready  = (state_q == S_ACCEPT);
  assign bus.mem_we    = (state_q == S_WRITE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = word_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign err           = err_q;
  assign wrapped       = wrapped_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: table of field sets with hand-computed
// words, a write scoreboard fed at handshake time and drained by a memory-side
// monitor, plus sequences for backpressure, bad opcode, wrap, reset and length 0.
module tb_instr_mem_loader;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] word;
    logic        bad;
  } vec_t;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] base_addr = '0;
  logic [10:0] length = '0;
  logic       busy, done, err, wrapped;

  int errors = 0;
  int checks = 0;
  exp_t q[$];
  vec_t vecs[10];

  instr_mem_loader_if #(.ADDR_W(10)) bus ();

  instr_mem_loader #(.ADDR_W(10), .LEN_W(11)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .wrapped   (wrapped)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Memory-side monitor: every accepted write must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && bus.mem_we && bus.mem_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got write addr=%0h data=%0h expected none",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.addr !== bus.mem_addr || e.data !== bus.mem_wdata) begin
          errors++;
          $display("FAIL sb_write: got addr=%0h data=%0h expected addr=%0h data=%0h",
                   bus.mem_addr, bus.mem_wdata, e.addr, e.data);
        end
      end
    end
  end

  function automatic vec_t mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] funct,
                              input logic [15:0] imm, input logic [25:0] tgt,
                              input logic [31:0] word, input logic bad);
    vec_t v;
    v.op = op; v.rs = rs; v.rt = rt; v.rd = rd; v.sh = sh; v.funct = funct;
    v.imm = imm; v.tgt = tgt; v.word = word; v.bad = bad;
    return v;
  endfunction

  task automatic do_start(input logic [9:0] base, input logic [10:0] len);
    base_addr = base;
    length    = len;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Present one field set, wait for the handshake, then check the cycle after it
  task automatic send(input vec_t v, input logic [9:0] addr, input bit push);
    int n = 0;
    bus.in_op = v.op; bus.in_rs = v.rs; bus.in_rt = v.rt; bus.in_rd = v.rd;
    bus.in_shamt = v.sh; bus.in_funct = v.funct; bus.in_imm = v.imm;
    bus.in_target = v.tgt;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!bus.in_ready) begin
      errors++;
      $display("FAIL hs_timeout: got in_ready=0 expected 1 within 20 cycles");
      bus.in_valid = 1'b0;
      return;
    end
    if (!v.bad && push) q.push_back({addr, v.word});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (v.bad) begin
      chk("drop_err", 32'(err), 32'd1);
      chk("drop_stay_accept", 32'(bus.in_ready), 32'd1);
      chk("drop_no_we", 32'(bus.mem_we), 32'd0);
    end else begin
      chk("lat1_we", 32'(bus.mem_we), 32'd1);
      chk("lat1_wdata", bus.mem_wdata, v.word);
      chk("lat1_addr", 32'(bus.mem_addr), 32'(addr));
      chk("write_rdy_low", 32'(bus.in_ready), 32'd0);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
    @(posedge clk); #1;
    chk("done_pulse_1cyc", 32'(done), 32'd0);
    chk("busy_fall", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [9:0] a;
    int ngood;

    vecs[0] = mk(6'h00, 5'd1,  5'd2,  5'd3,  5'd0,  6'h20, 16'h0000, 26'h0, 32'h00221820, 1'b0);
    vecs[1] = mk(6'h23, 5'd29, 5'd8,  5'd7,  5'd9,  6'h11, 16'h0004, 26'h0, 32'h8FA80004, 1'b0);
    vecs[2] = mk(6'h04, 5'd1,  5'd2,  5'd0,  5'd0,  6'h00, 16'hFFFF, 26'h0, 32'h1022FFFF, 1'b0);
    vecs[3] = mk(6'h02, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h1234, 26'h0100000, 32'h08100000, 1'b0);
    vecs[4] = mk(6'h3F, 5'd1,  5'd1,  5'd1,  5'd1,  6'h01, 16'h0001, 26'h1, 32'h00000000, 1'b1);
    vecs[5] = mk(6'h08, 5'd3,  5'd4,  5'd0,  5'd0,  6'h00, 16'h0010, 26'h0, 32'h20640010, 1'b0);
    vecs[6] = mk(6'h36, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 32'hD8000000, 1'b0);
    vecs[7] = mk(6'h00, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'h0000, 26'h0, 32'h03FFFFFF, 1'b0);
    vecs[8] = mk(6'h0D, 5'd0,  5'd5,  5'd0,  5'd0,  6'h00, 16'hABCD, 26'h0, 32'h3405ABCD, 1'b0);
    vecs[9] = mk(6'h03, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 26'h3FFFFFF, 32'h0FFFFFFF, 1'b0);

    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_rs = '0; bus.in_rt = '0; bus.in_rd = '0;
    bus.in_shamt = '0; bus.in_funct = '0; bus.in_imm = '0; bus.in_target = '0;
    bus.mem_ready = 1'b1;

    // Reset state
    #2;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_status", {28'd0, busy, done, err, wrapped}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // R-type single word
    do_start(10'h010, 11'd1);
    chk("r_busy", 32'(busy), 32'd1);
    send(vecs[0], 10'h010, 1'b1);
    wait_done();

    // Table-driven load: all vectors, the bad one dropped, good ones consecutive
    ngood = 0;
    foreach (vecs[i]) if (!vecs[i].bad) ngood++;
    do_start(10'h040, 11'(ngood));
    a = 10'h040;
    for (int i = 0; i < 10; i++) begin
      send(vecs[i], a, 1'b1);
      if (!vecs[i].bad) a = a + 10'd1;
    end
    wait_done();
    chk("table_err_sticky", 32'(err), 32'd1);

    // I-type pair at consecutive addresses
    do_start(10'h080, 11'd2);
    chk("start_clears_err", 32'(err), 32'd0);
    send(vecs[1], 10'h080, 1'b1);
    send(vecs[2], 10'h081, 1'b1);
    wait_done();

    // J with mem_ready low for 3 cycles
    do_start(10'h200, 11'd1);
    bus.mem_ready = 1'b0;
    send(vecs[3], 10'h200, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      chk("bp_we", 32'(bus.mem_we), 32'd1);
      chk("bp_addr", 32'(bus.mem_addr), 32'h200);
      chk("bp_wdata", bus.mem_wdata, 32'h08100000);
      chk("bp_rdy_low", 32'(bus.in_ready), 32'd0);
    end
    bus.mem_ready = 1'b1;
    wait_done();

    // Bad opcode first: ADDI lands at base_addr
    do_start(10'h100, 11'd2);
    send(vecs[4], 10'h100, 1'b1);
    send(vecs[5], 10'h100, 1'b1);
    chk("bad_not_done_yet", 32'(done), 32'd0);
    send(vecs[6], 10'h101, 1'b1);
    wait_done();
    chk("bad_err", 32'(err), 32'd1);
    chk("bad_no_wrap", 32'(wrapped), 32'd0);

    // Address wrap
    do_start(10'h3FF, 11'd2);
    send(vecs[7], 10'h3FF, 1'b1);
    send(vecs[8], 10'h000, 1'b1);
    wait_done();
    chk("wrap_flag", 32'(wrapped), 32'd1);
    chk("wrap_err_cleared", 32'(err), 32'd0);

    // Zero length: done right after start, no write
    do_start(10'h123, 11'd0);
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_no_we", 32'(bus.mem_we), 32'd0);
    @(posedge clk); #1;
    chk("len0_idle", 32'(busy), 32'd0);
    chk("len0_wrap_held", 32'(wrapped), 32'd1);

    // Reset while a write is pending
    do_start(10'h300, 11'd1);
    bus.mem_ready = 1'b0;
    send(vecs[0], 10'h300, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_rdy", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    do_start(10'h020, 11'd1);
    send(vecs[5], 10'h020, 1'b1);
    wait_done();
    chk("after_rst_no_wrap", 32'(wrapped), 32'd0);

    @(posedge clk); #1;
    chk("sb_drained", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
